// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: round-robin arbiter that gives two requesters access to one register file.
// A grant latches the whole transaction; responses arrive through a small fixed-latency FSM.
module reg_file_arbiter #(
  parameter int P_RegCount = 3,
  parameter int P_BitWidth = 32,
  localparam int AW = (P_RegCount > 1) ? $clog2(P_RegCount) : 1
) (
  input  logic                  In_Clock,
  input  logic                  In_Reset,
  input  logic                  In_ReqA,
  input  logic                  In_ReqB,
  input  logic                  In_WriteA,
  input  logic                  In_WriteB,
  input  logic [AW-1:0]         In_AddressA,
  input  logic [AW-1:0]         In_AddressB,
  input  logic [P_BitWidth-1:0] In_WriteDataA,
  input  logic [P_BitWidth-1:0] In_WriteDataB,
  output logic                  Out_DoneA,
  output logic                  Out_DoneB,
  output logic [P_BitWidth-1:0] Out_ReadDataA,
  output logic [P_BitWidth-1:0] Out_ReadDataB,
  output logic                  Out_Error,
  output logic [AW-1:0]         Out_RF_Address,
  output logic [P_BitWidth-1:0] Out_RF_WriteData,
  output logic                  Out_RF_Write,
  output logic                  Out_RF_Read,
  input  logic [P_BitWidth-1:0] In_RF_ReadData,
  output logic                  Out_Busy,
  output logic                  Out_Owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state;
  logic prio_b, wr, err;
  logic grant_b, oor_a, oor_b;
  // B wins when alone, or on a tie when A was served last
  assign grant_b = In_ReqB & (~In_ReqA | prio_b);
  assign oor_a = 32'(In_AddressA) >= P_RegCount;
  assign oor_b = 32'(In_AddressB) >= P_RegCount;
  assign Out_Busy = state != IDLE;
  always_ff @(posedge In_Clock or posedge In_Reset) begin
    if (In_Reset) begin
      state <= IDLE;
      prio_b <= 1'b0;
      wr <= 1'b0;
      err <= 1'b0;
      Out_Owner <= 1'b0;
      Out_DoneA <= 1'b0;
      Out_DoneB <= 1'b0;
      Out_Error <= 1'b0;
      Out_ReadDataA <= '0;
      Out_ReadDataB <= '0;
      Out_RF_Address <= '0;
      Out_RF_WriteData <= '0;
      Out_RF_Write <= 1'b0;
      Out_RF_Read <= 1'b0;
    end else begin
      Out_DoneA <= 1'b0;
      Out_DoneB <= 1'b0;
      Out_Error <= 1'b0;
      Out_RF_Write <= 1'b0;
      Out_RF_Read <= 1'b0;
      case (state)
        IDLE: if (In_ReqA | In_ReqB) begin
          Out_Owner <= grant_b;
          prio_b <= ~grant_b;
          wr <= grant_b ? In_WriteB : In_WriteA;
          err <= grant_b ? oor_b : oor_a;
          Out_RF_Address <= grant_b ? In_AddressB : In_AddressA;
          Out_RF_WriteData <= grant_b ? In_WriteDataB : In_WriteDataA;
          Out_RF_Write <= grant_b ? In_WriteB & ~oor_b : In_WriteA & ~oor_a;
          Out_RF_Read <= grant_b ? ~In_WriteB & ~oor_b : ~In_WriteA & ~oor_a;
          state <= ISSUE;
        end
        ISSUE: state <= wr ? RESP : CAPTURE;
        CAPTURE: begin
          if (Out_Owner) Out_ReadDataB <= err ? '0 : In_RF_ReadData;
          else Out_ReadDataA <= err ? '0 : In_RF_ReadData;
          state <= RESP;
        end
        default: begin
          Out_DoneA <= ~Out_Owner;
          Out_DoneB <= Out_Owner;
          Out_Error <= err;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: randomized transaction-level checks against a register-file and arbitration model.
module tb_reg_file_arbiter;
  logic clk = 0, rst = 0;
  logic req_a = 0, req_b = 0, write_a = 0, write_b = 0;
  logic [1:0] addr_a = 0, addr_b = 0;
  logic [31:0] wd_a = 0, wd_b = 0;
  logic done_a, done_b, error, rf_write, rf_read, busy, owner;
  logic [31:0] rd_a, rd_b, rf_wd, rf_rdata;
  logic [1:0] rf_address;
  logic [31:0] rf_mem [4];
  logic [31:0] exp_mem [3];
  logic [31:0] exp_rd [2];
  int last_served = -1;
  int wr_cnt = 0, rd_cnt = 0, both_err = 0, dd_err = 0;
  logic [1:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  reg_file_arbiter dut (
    .In_Clock(clk), .In_Reset(rst),
    .In_ReqA(req_a), .In_ReqB(req_b),
    .In_WriteA(write_a), .In_WriteB(write_b),
    .In_AddressA(addr_a), .In_AddressB(addr_b),
    .In_WriteDataA(wd_a), .In_WriteDataB(wd_b),
    .Out_DoneA(done_a), .Out_DoneB(done_b),
    .Out_ReadDataA(rd_a), .Out_ReadDataB(rd_b),
    .Out_Error(error),
    .Out_RF_Address(rf_address), .Out_RF_WriteData(rf_wd),
    .Out_RF_Write(rf_write), .Out_RF_Read(rf_read),
    .In_RF_ReadData(rf_rdata),
    .Out_Busy(busy), .Out_Owner(owner)
  );

  // attached register file: read data is valid only the cycle after a read strobe
  always @(posedge clk) begin
    if (rf_write && rf_read) both_err = both_err + 1;
    if (done_a && done_b) dd_err = dd_err + 1;
    if (rf_write) begin
      wr_cnt = wr_cnt + 1;
      wr_addr = rf_address;
      wr_data = rf_wd;
      rf_mem[rf_address] = rf_wd;
    end
    if (rf_read) begin
      rd_cnt = rd_cnt + 1;
      rd_addr = rf_address;
    end
    rf_rdata <= rf_read ? rf_mem[rf_address] : $urandom;
  end

  task automatic do_txn(input bit b, input bit w, input logic [1:0] a, input logic [31:0] d);
    int wc0 = wr_cnt, rc0 = rd_cnt, k = 0;
    bit oor = (a == 2'd3);
    if (b) begin req_b = 1; write_b = w; addr_b = a; wd_b = d; end
    else begin req_a = 1; write_a = w; addr_a = a; wd_a = d; end
    @(posedge clk); #1;
    req_a = 0; req_b = 0;
    addr_a = 2'($urandom); addr_b = 2'($urandom); wd_a = $urandom; wd_b = $urandom;
    write_a = 1'($urandom); write_b = 1'($urandom);
    total++; if (owner !== b || busy !== 1'b1) $display("FAIL grant owner=%b busy=%b want owner=%b busy=1", owner, busy, b); else passed++;
    do begin @(posedge clk); #1; k++; end while (!(done_a | done_b) && k < 8);
    total++; if (k != (w ? 2 : 3)) $display("FAIL latency got %0d want %0d (w=%b)", k, w ? 2 : 3, w); else passed++;
    total++; if ({done_a, done_b} !== (b ? 2'b01 : 2'b10)) $display("FAIL done_sel got %b want %b", {done_a, done_b}, b ? 2'b01 : 2'b10); else passed++;
    total++; if (error !== oor) $display("FAIL error got %b want %b addr=%0d", error, oor, a); else passed++;
    if (!w) exp_rd[b] = oor ? 32'h0 : exp_mem[a];
    if (w && !oor) exp_mem[a] = d;
    total++; if (rd_a !== exp_rd[0] || rd_b !== exp_rd[1]) $display("FAIL read_data got %h/%h want %h/%h", rd_a, rd_b, exp_rd[0], exp_rd[1]); else passed++;
    total++; if (wr_cnt - wc0 != int'(w && !oor) || rd_cnt - rc0 != int'(!w && !oor))
      $display("FAIL strobes got wr=%0d rd=%0d want wr=%0d rd=%0d", wr_cnt - wc0, rd_cnt - rc0, int'(w && !oor), int'(!w && !oor)); else passed++;
    if (w && !oor) begin
      total++; if (wr_addr !== a || wr_data !== d) $display("FAIL write_latch got %0d/%h want %0d/%h", wr_addr, wr_data, a, d); else passed++;
    end
    if (!w && !oor) begin
      total++; if (rd_addr !== a) $display("FAIL read_latch got %0d want %0d", rd_addr, a); else passed++;
    end
    last_served = b;
  endtask

  task automatic test_reset();
    rst = 0; #2 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy, owner, done_a, done_b, error, rf_write, rf_read} !== 7'b0)
      $display("FAIL reset_flags got %b want 0", {busy, owner, done_a, done_b, error, rf_write, rf_read}); else passed++;
    total++; if (rd_a !== 0 || rd_b !== 0 || rf_address !== 0 || rf_wd !== 0)
      $display("FAIL reset_data got %h %h %h %h want 0", rd_a, rd_b, rf_address, rf_wd); else passed++;
    rst = 0;
    last_served = -1;
    exp_rd[0] = 0; exp_rd[1] = 0;
  endtask

  task automatic test_write_read();
    do_txn(0, 1, 2'd2, 32'hDEADBEEF);
    do_txn(0, 0, 2'd2, 32'h0);
    total++; if (rd_a !== 32'hDEADBEEF || rd_b !== 32'h0) $display("FAIL write_read got %h/%h want deadbeef/0", rd_a, rd_b); else passed++;
  endtask

  task automatic test_out_of_range();
    do_txn(1, 0, 2'd2, 32'h0);
    do_txn(1, 0, 2'd3, 32'h0);
    total++; if (rd_b !== 32'h0) $display("FAIL oor_read got %h want 0", rd_b); else passed++;
    do_txn(0, 1, 2'd3, 32'h12345678);
  endtask

  task automatic test_round_robin(input int n);
    req_a = 1; req_b = 1; write_a = 1; write_b = 1; addr_a = 0; addr_b = 1;
    wd_a = $urandom; wd_b = $urandom;
    for (int i = 0; i < n; i++) begin
      int k = 0;
      bit win = (last_served == 0);
      do begin @(posedge clk); #1; k++; end while (!(done_a | done_b) && k < 10);
      total++; if (k != 3) $display("FAIL rr_latency[%0d] got %0d want 3", i, k); else passed++;
      total++; if ({done_a, done_b} !== {!win, win} || owner !== win)
        $display("FAIL rr_grant[%0d] got done=%b owner=%b want done=%b owner=%b", i, {done_a, done_b}, owner, {!win, win}, win); else passed++;
      exp_mem[win ? 1 : 0] = win ? wd_b : wd_a;
      last_served = win;
    end
    req_a = 0; req_b = 0;
    total++; if (rf_mem[0] !== exp_mem[0] || rf_mem[1] !== exp_mem[1]) $display("FAIL rr_mem got %h/%h want %h/%h", rf_mem[0], rf_mem[1], exp_mem[0], exp_mem[1]); else passed++;
  endtask

  task automatic test_random();
    repeat (24) do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    req_a = 1; write_a = 0; addr_a = 2'd2;
    @(posedge clk); #1;
    req_a = 0;
    @(posedge clk); #1;
    rst = 1; #1;
    total++; if ({busy, owner, done_a, done_b, error, rf_write, rf_read} !== 7'b0)
      $display("FAIL midreset_flags got %b want 0", {busy, owner, done_a, done_b, error, rf_write, rf_read}); else passed++;
    total++; if (rd_a !== 0 || rd_b !== 0 || rf_address !== 0 || rf_wd !== 0)
      $display("FAIL midreset_data got %h %h %h %h want 0", rd_a, rd_b, rf_address, rf_wd); else passed++;
    exp_rd[0] = 0; exp_rd[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    last_served = -1;
    repeat (4) begin @(posedge clk); #1; seen = seen | done_a; end
    total++; if (seen) $display("FAIL midreset_done got 1 want 0"); else passed++;
  endtask

  task automatic test_invariants();
    total++; if (both_err != 0) $display("FAIL both_strobes got %0d want 0", both_err); else passed++;
    total++; if (dd_err != 0) $display("FAIL double_done got %0d want 0", dd_err); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf_mem[i] = 0;
    for (int i = 0; i < 3; i++) exp_mem[i] = 0;
    exp_rd[0] = 0; exp_rd[1] = 0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_round_robin(4);
    test_random();
    test_reset_mid();
    test_round_robin(2);
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 SHALL have parameter P_RegCount, default 3: number of registers in the attached register file.
REQ-002 SHALL have parameter P_BitWidth, default 32: data width.
REQ-003 SHALL define AW = $clog2(P_RegCount), with a minimum of 1.
REQ-004 In_Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 In_Reset  input  1  asynchronous, active-high reset.
REQ-006 In_ReqA, In_ReqB  input  1  each  access request from requester A / B (level).
REQ-007 In_WriteA, In_WriteB  input  1  each  1 = write, 0 = read.
REQ-008 In_AddressA, In_AddressB  input  AW  each  target register.
REQ-009 In_WriteDataA, In_WriteDataB  input  P_BitWidth  each  write data.
REQ-010 Out_DoneA, Out_DoneB  output  1  each  one-cycle completion pulse.
REQ-011 Out_ReadDataA, Out_ReadDataB  output  P_BitWidth  each  last read result per requester.
REQ-012 Out_Error  output  1  one-cycle pulse, coincident with Done, for an out-of-range address.
REQ-013 Out_RF_Address  output  AW  register-file address.
REQ-014 Out_RF_WriteData  output  P_BitWidth  register-file write data.
REQ-015 Out_RF_Write, Out_RF_Read  output  1  each  register-file strobes.
REQ-016 In_RF_ReadData  input  P_BitWidth  register-file read data, valid the cycle after Out_RF_Read.
REQ-017 Out_Busy  output  1  high in any state other than IDLE.
REQ-018 Out_Owner  output  1  0 = A, 1 = B; the current or most recent grant.

Function
REQ-019 SHALL implement an FSM with states IDLE, ISSUE, CAPTURE and RESP.
REQ-020 IDLE: on an edge with any In_ReqX high, SHALL grant one requester, latch its write flag, address and data, update Out_Owner, and go to ISSUE.
REQ-021 SHALL arbitrate round-robin: a lone request wins; with both requesting, the requester not most recently served wins.
REQ-022 After reset, A SHALL have priority.
REQ-023 ISSUE: SHALL assert Out_RF_Write or Out_RF_Read for exactly this one cycle, then go to RESP on a write or CAPTURE on a read.
REQ-024 CAPTURE: SHALL register In_RF_ReadData into Out_ReadData of the owner, then go to RESP.
REQ-025 RESP: SHALL pulse the owner's Out_DoneX for one cycle and return to IDLE.
REQ-026 Latency SHALL be: write Done 2 cycles after the grant edge; read Done 3 cycles after the grant edge.
REQ-027 Out_ReadDataX SHALL change only on that requester's own read completion, and hold otherwise.
REQ-028 Out_RF_Address and Out_RF_WriteData SHALL reflect the latched transaction from ISSUE through CAPTURE.
REQ-029 Both strobes SHALL be 0 outside ISSUE, and never both 1 at once.
REQ-030 Requester input changes after the grant edge SHALL be ignored for that transaction.
REQ-031 An In_ReqX still high in the IDLE cycle after its Done SHALL be treated as a new request.
REQ-032 Address >= P_RegCount: SHALL assert no strobe in ISSUE, pulse Out_Error with Done, and for a read load zero into Out_ReadDataX.
REQ-033 A request arriving while Busy SHALL wait; it SHALL NOT be dropped while held high.
REQ-034 Maximum throughput SHALL be one transaction per 3 cycles (write) or 4 cycles (read).

Reset
REQ-035 In_Reset high SHALL immediately force: state IDLE; all outputs 0, including Out_Owner, Out_ReadDataA/B and Out_RF_* (strobes cancelled asynchronously); priority to A.
REQ-036 A transaction interrupted by reset SHALL be dropped with no Done.
REQ-037 The first grant SHALL be possible on the first rising edge after In_Reset falls.

Verification
REQ-038 A writes 0xDEADBEEF to register 2, then reads register 2 -> Out_RF_Write pulses once with address 2; read Done 3 cycles after grant; Out_ReadDataA = 0xDEADBEEF; Out_ReadDataB stays 0.
REQ-039 ReqA and ReqB rise together and stay high -> grants go A, B, A, B in that order; Out_Owner tracks each grant; no cycle has two Done pulses.
REQ-040 B reads address 3 with P_RegCount = 3 -> no strobe; Out_DoneB and Out_Error pulse together; Out_ReadDataB = 0.
REQ-041 In_Reset asserted during CAPTURE of a read by A -> outputs zero at once; no Out_DoneA; next request after release is granted to A.
REQ-042 A changes In_AddressA and In_WriteDataA in the cycle after its grant -> the register file sees the originally latched values.
